// File: rtl/usermem_arbiter.sv
// usermem_arbiter: shares the single-port synchronous user memory between the
// CPU control unit (absolute priority, never stalled) and one external
// requester (valid/ready request channel, one-cycle read-return pulse).
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cpu_req/we/addr/wdata      CPU access, owns the memory whenever cpu_req=1
//   cpu_rdata                  CPU read data (straight from mem_rdata)
//   ext_valid/ready/we/addr/wdata  external request channel
//   ext_rvalid/ext_rdata       external read return (registered, 1-cycle pulse)
//   starve                     external request blocked >= STARVE_LIMIT cycles
//   mem_addr/we/wdata/rdata    memory macro port (rdata one cycle after addr)
module usermem_arbiter #(
  parameter int AW           = 8,
  parameter int DW           = 8,
  parameter int STARVE_LIMIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ext_valid,
  output logic          ext_ready,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_rvalid,
  output logic [DW-1:0] ext_rdata,
  output logic          starve,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, PEND, RDWAIT} state_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t          state_q, state_d;
  logic            buf_we_q, buf_we_d;
  logic [AW-1:0]   buf_addr_q, buf_addr_d;
  logic [DW-1:0]   buf_wdata_q, buf_wdata_d;
  logic [7:0]      wait_q, wait_d;
  logic [DW-1:0]   ext_rdata_q, ext_rdata_d;
  logic            ext_rvalid_q, ext_rvalid_d;
  logic            starve_q, starve_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      buf_we_q     <= 1'b0;
      buf_addr_q   <= '0;
      buf_wdata_q  <= '0;
      wait_q       <= '0;
      ext_rdata_q  <= '0;
      ext_rvalid_q <= 1'b0;
      starve_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_we_q     <= buf_we_d;
      buf_addr_q   <= buf_addr_d;
      buf_wdata_q  <= buf_wdata_d;
      wait_q       <= wait_d;
      ext_rdata_q  <= ext_rdata_d;
      ext_rvalid_q <= ext_rvalid_d;
      starve_q     <= starve_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    buf_we_d     = buf_we_q;
    buf_addr_d   = buf_addr_q;
    buf_wdata_d  = buf_wdata_q;
    wait_d       = wait_q;
    ext_rdata_d  = ext_rdata_q;
    ext_rvalid_d = 1'b0;
    starve_d     = starve_q;
    case (state_q)
      IDLE: begin
        wait_d   = '0;
        starve_d = 1'b0;
        // ext_ready is 1 whenever we are in IDLE out of reset
        if (ext_valid) begin
          buf_we_d    = ext_we;
          buf_addr_d  = ext_addr;
          buf_wdata_d = ext_wdata;
          state_d     = PEND;
        end
      end
      PEND: begin
        if (cpu_req) begin
          wait_d   = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
          // sticky until the buffered access finally issues
          starve_d = starve_q | (wait_d >= LIMIT);
        end else begin
          state_d  = buf_we_q ? IDLE : RDWAIT;
          wait_d   = '0;
          starve_d = 1'b0;
        end
      end
      RDWAIT: begin
        // mem_rdata reflects the address issued last cycle, so a CPU access
        // now cannot disturb the captured value
        ext_rdata_d  = mem_rdata;
        ext_rvalid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (cpu_req) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_wdata = cpu_wdata;
    end else if (state_q == PEND) begin
      mem_addr  = buf_addr_q;
      mem_we    = buf_we_q;
      mem_wdata = buf_wdata_q;
    end
    // no writes reach the macro while reset is held
    if (reset) mem_we = 1'b0;
  end

  assign ext_ready  = (state_q == IDLE) && !reset;
  assign cpu_rdata  = mem_rdata;
  assign ext_rdata  = ext_rdata_q;
  assign ext_rvalid = ext_rvalid_q;
  assign starve     = starve_q;

endmodule

// File: tb/tb_usermem_arbiter.sv
module tb_usermem_arbiter;
  logic       clk, reset;
  logic       cpu_req, cpu_we;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       ext_valid, ext_ready, ext_we, ext_rvalid, starve;
  logic [7:0] ext_addr, ext_wdata, ext_rdata;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we;

  logic [7:0] mem [256];
  logic [7:0] sb [$];
  int n_pass = 0;
  int n_chk  = 0;

  usermem_arbiter #(.AW(8), .DW(8), .STARVE_LIMIT(15)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_we(ext_we),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata), .starve(starve),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous single-port memory, read-before-write
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // scoreboard: every ext_rvalid pulse must match the oldest expected read
  always @(negedge clk) begin
    if (ext_rvalid === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_rvalid", 32'(ext_rvalid), 32'd0);
      else                chk("sb_rdata", 32'(ext_rdata), 32'(sb.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cpu(input logic req, input logic we, input logic [7:0] a, input logic [7:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic ext(input logic v, input logic we, input logic [7:0] a, input logic [7:0] d);
    ext_valid = v; ext_we = we; ext_addr = a; ext_wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_rdata = 8'h00;
    cpu(0, 0, 8'h00, 8'h00);
    ext(0, 0, 8'h00, 8'h00);
    reset = 1'b1;

    // reset: CPU asking to write must not reach memory, ext not ready
    step(); cpu(1, 1, 8'h11, 8'h22); #1;
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_ready", 32'(ext_ready), 32'd0);
    step(); #1;
    chk("rst_rvalid", 32'(ext_rvalid), 32'd0);
    chk("rst_starve", 32'(starve), 32'd0);
    chk("rst_rdata", 32'(ext_rdata), 32'd0);
    reset = 1'b0; cpu(0, 0, 8'h00, 8'h00); #1;
    chk("post_rst_ready", 32'(ext_ready), 32'd1);
    chk("idle_mem_addr", 32'(mem_addr), 32'd0);

    // preload through the CPU path
    step(); cpu(1, 1, 8'h20, 8'h3C); #1;
    chk("cpu_wr_we", 32'(mem_we), 32'd1);
    chk("cpu_wr_addr", 32'(mem_addr), 32'h20);
    step(); cpu(1, 1, 8'h30, 8'h5A);
    step(); cpu(1, 1, 8'h50, 8'hC3);
    step(); cpu(0, 0, 8'h00, 8'h00);

    // uncontended ext write
    step(); ext(1, 1, 8'h10, 8'hA5); #1;
    chk("wr_c0_ready", 32'(ext_ready), 32'd1);
    step(); ext(0, 0, 8'h00, 8'h00); #1;
    chk("wr_c1_we", 32'(mem_we), 32'd1);
    chk("wr_c1_addr", 32'(mem_addr), 32'h10);
    chk("wr_c1_wdata", 32'(mem_wdata), 32'hA5);
    chk("wr_c1_ready", 32'(ext_ready), 32'd0);
    step(); #1;
    chk("wr_c2_ready", 32'(ext_ready), 32'd1);
    chk("wr_c2_we", 32'(mem_we), 32'd0);
    cpu(1, 0, 8'h10, 8'h00);
    step(); cpu(0, 0, 8'h00, 8'h00); #1;
    chk("wr_readback", 32'(cpu_rdata), 32'hA5);

    // uncontended ext read
    step(); ext(1, 0, 8'h20, 8'h00); sb.push_back(8'h3C);
    step(); ext(0, 0, 8'h00, 8'h00); #1;
    chk("rd_c1_addr", 32'(mem_addr), 32'h20);
    chk("rd_c1_we", 32'(mem_we), 32'd0);
    step(); #1;
    chk("rd_c2_rvalid", 32'(ext_rvalid), 32'd0);
    step(); #1;
    chk("rd_c3_rvalid", 32'(ext_rvalid), 32'd1);
    chk("rd_c3_rdata", 32'(ext_rdata), 32'h3C);
    step(); #1;
    chk("rd_c4_rvalid", 32'(ext_rvalid), 32'd0);

    // contention: CPU writes 0x40 for 4 cycles while ext read 0x30 waits
    step(); ext(1, 0, 8'h30, 8'h00); sb.push_back(8'h5A);
    for (int i = 0; i < 4; i++) begin
      step(); ext(0, 0, 8'h00, 8'h00); cpu(1, 1, 8'h40, 8'h77); #1;
      chk("cont_addr", 32'(mem_addr), 32'h40);
      chk("cont_wdata", 32'(mem_wdata), 32'h77);
      chk("cont_ready", 32'(ext_ready), 32'd0);
    end
    step(); cpu(0, 0, 8'h00, 8'h00); #1;
    chk("cont_issue_addr", 32'(mem_addr), 32'h30);
    chk("cont_issue_we", 32'(mem_we), 32'd0);
    // CPU reads 0x40 during RDWAIT; captured ext data must stay intact
    step(); cpu(1, 0, 8'h40, 8'h00); #1;
    chk("cont_rdwait_rvalid", 32'(ext_rvalid), 32'd0);
    chk("cont_rdwait_addr", 32'(mem_addr), 32'h40);
    step(); cpu(0, 0, 8'h00, 8'h00); #1;
    chk("cont_rvalid", 32'(ext_rvalid), 32'd1);
    chk("cont_rdata", 32'(ext_rdata), 32'h5A);
    chk("cont_cpu_rdata", 32'(cpu_rdata), 32'h77);

    // starvation: 20 blocked cycles, starve visible from the 16th cycle on
    step(); ext(1, 0, 8'h50, 8'h00); sb.push_back(8'hC3);
    for (int i = 1; i <= 20; i++) begin
      step(); ext(0, 0, 8'h00, 8'h00); cpu(1, 1, 8'h60, 8'(i)); #1;
      chk($sformatf("starve_c%0d", i), 32'(starve), 32'(i >= 16));
    end
    step(); cpu(0, 0, 8'h00, 8'h00); #1;
    chk("starve_issue_cycle", 32'(starve), 32'd1);
    chk("starve_issue_addr", 32'(mem_addr), 32'h50);
    step(); #1;
    chk("starve_cleared", 32'(starve), 32'd0);
    step(); #1;
    chk("starve_rvalid", 32'(ext_rvalid), 32'd1);
    step();

    // reset in the RDWAIT cycle drops the read
    ext(1, 0, 8'h20, 8'h00);
    step(); ext(0, 0, 8'h00, 8'h00);
    step(); reset = 1'b1; #1;
    chk("mid_rst_ready", 32'(ext_ready), 32'd0);
    step(); reset = 1'b0; #1;
    chk("mid_rst_rvalid", 32'(ext_rvalid), 32'd0);
    chk("mid_rst_ready_after", 32'(ext_ready), 32'd1);
    chk("mid_rst_rdata", 32'(ext_rdata), 32'd0);
    step(); #1;
    chk("mid_rst_rvalid2", 32'(ext_rvalid), 32'd0);

    // handshake: request held with a changing address while pending
    ext(1, 0, 8'h20, 8'h00); sb.push_back(8'h3C);
    step(); ext(1, 0, 8'h30, 8'h00); cpu(1, 0, 8'h60, 8'h00); #1;
    chk("hs_c1_ready", 32'(ext_ready), 32'd0);
    step(); ext(1, 0, 8'h50, 8'h00); #1;
    chk("hs_c2_addr", 32'(mem_addr), 32'h60);
    step(); ext(1, 0, 8'h30, 8'h00); cpu(0, 0, 8'h00, 8'h00); #1;
    chk("hs_buffered_addr", 32'(mem_addr), 32'h20);
    step(); #1;
    chk("hs_rdwait_ready", 32'(ext_ready), 32'd0);
    step(); sb.push_back(8'h5A); #1;
    chk("hs_rvalid", 32'(ext_rvalid), 32'd1);
    chk("hs_rdata", 32'(ext_rdata), 32'h3C);
    chk("hs_ready_again", 32'(ext_ready), 32'd1);
    step(); ext(0, 0, 8'h00, 8'h00); #1;
    chk("hs_second_addr", 32'(mem_addr), 32'h30);
    step(); step(); step(); #1;

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
